// File: rtl/arb_4req_prio_pkg.sv
// rtl/arb_4req_prio_pkg.sv - shared encodings and constants for the 4-requester arbiter
package arb_4req_prio_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int CNT_W = 8;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/arb_4req_prio_pick.sv
// rtl/arb_4req_prio_pick.sv - rotate-then-priority-encode: first set req at start, start-1, ... with wrap
module prio_pick_4 (
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic [1:0] idx,
    output logic       any
);

    always_comb begin
        idx = start;
        any = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!any && req[start - 2'(k)]) begin
                idx = start - 2'(k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_4req_prio.sv
// rtl/arb_4req_prio.sv - fixed-priority / round-robin arbiter with done, drop and hold-timeout release
module arb_4req_prio
    import arb_4req_prio_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam logic             HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state, state_n;
    logic [3:0]       gnt_n;
    logic [1:0]       gnt_id_n;
    logic             busy_n, timeout_n;
    logic [1:0]       last, last_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       start, pick_idx;
    logic             pick_any;
    logic             rel_done, rel_drop, rel_hold;

    // The last winner sits at the bottom of the round-robin order.
    assign start = (mode == MODE_RR) ? last - 2'd1 : 2'd3;

    prio_pick_4 u_pick (
        .req   (req),
        .start (start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign rel_done = done;
    assign rel_drop = ~req[gnt_id];
    assign rel_hold = HOLD_EN && (cnt == HOLD_LAST);

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        busy_n    = busy;
        timeout_n = 1'b0;
        last_n    = last;
        cnt_n     = cnt;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_n  = ST_GRANT;
                    gnt_n    = onehot4(pick_idx);
                    gnt_id_n = pick_idx;
                    busy_n   = 1'b1;
                    cnt_n    = '0;
                end
            end
            ST_GRANT: begin
                if (rel_done || rel_drop || rel_hold) begin
                    state_n   = ST_IDLE;
                    gnt_n     = 4'b0000;
                    busy_n    = 1'b0;
                    last_n    = gnt_id;
                    timeout_n = rel_hold && !rel_done && !rel_drop;
                end else if (cnt != {CNT_W{1'b1}}) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt     <= 4'b0000;
            gnt_id  <= 2'b00;
            busy    <= 1'b0;
            timeout <= 1'b0;
            last    <= 2'b00;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            gnt_id  <= gnt_id_n;
            busy    <= busy_n;
            timeout <= timeout_n;
            last    <= last_n;
            cnt     <= cnt_n;
        end
    end

endmodule

// File: tb/tb_arb_4req_prio.sv
// tb/tb_arb_4req_prio.sv - randomized and directed checks of arb_4req_prio against a grant-level model
module tb_arb_4req_prio;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       mode = 1'b0;
    logic       done = 1'b0;
    logic [3:0] req  = 4'b0000;

    logic [3:0] gnt_o     [2];
    logic [1:0] gnt_id_o  [2];
    logic       busy_o    [2];
    logic       timeout_o [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    arb_4req_prio #(.HOLD_MAX(4)) u_dut_h4 (
        .clk(clk), .rst(rst), .mode(mode), .req(req), .done(done),
        .gnt(gnt_o[0]), .gnt_id(gnt_id_o[0]), .busy(busy_o[0]), .timeout(timeout_o[0])
    );

    arb_4req_prio #(.HOLD_MAX(1)) u_dut_h1 (
        .clk(clk), .rst(rst), .mode(mode), .req(req), .done(done),
        .gnt(gnt_o[1]), .gnt_id(gnt_id_o[1]), .busy(busy_o[1]), .timeout(timeout_o[1])
    );

    // Reference: who holds the resource, for how many cycles, and who won last.
    typedef struct packed {
        logic        busy;
        logic [1:0]  holder;
        logic [1:0]  last;
        logic [15:0] len;
        logic        to;
    } mstate_t;

    mstate_t ms [2];

    function automatic logic [1:0] pick(input logic [3:0] r, input logic m, input logic [1:0] lst);
        if (!m) begin
            for (int p = 3; p >= 0; p--)
                if (r[p]) return 2'(p);
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int p;
                p = (int'(lst) + 4 - k) % 4;
                if (r[p]) return 2'(p);
            end
        end
        return 2'd0;
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input int hold, input logic [3:0] r,
                                      input logic d, input logic m);
        mstate_t n;
        n    = s;
        n.to = 1'b0;
        if (!s.busy) begin
            if (r != 4'b0000) begin
                n.busy   = 1'b1;
                n.holder = pick(r, m, s.last);
                n.len    = 16'd1;
            end
        end else begin
            logic fa, fb, fc;
            fa = d;
            fb = !r[s.holder];
            fc = (hold != 0) && (int'(s.len) == hold);
            if (fa || fb || fc) begin
                n.busy = 1'b0;
                n.last = s.holder;
                n.to   = fc && !fa && !fb;
            end else begin
                n.len = s.len + 16'd1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ms[0] <= '0;
            ms[1] <= '0;
        end else begin
            ms[0] <= mstep(ms[0], 4, req, done, mode);
            ms[1] <= mstep(ms[1], 1, req, done, mode);
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic [3:0] eg;
            eg = ms[i].busy ? (4'b0001 << ms[i].holder) : 4'b0000;
            chk($sformatf("i%0d_gnt", i),     {4'b0, gnt_o[i]},     {4'b0, eg});
            chk($sformatf("i%0d_gnt_id", i),  {6'b0, gnt_id_o[i]},  {6'b0, ms[i].holder});
            chk($sformatf("i%0d_busy", i),    {7'b0, busy_o[i]},    {7'b0, ms[i].busy});
            chk($sformatf("i%0d_timeout", i), {7'b0, timeout_o[i]}, {7'b0, ms[i].to});
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d, input logic m);
        @(negedge clk);
        compare_all();
        req  = r;
        done = d;
        mode = m;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         seq[$];
        int         rr_exp[5];
        logic [3:0] r;
        rr_exp = '{3, 2, 1, 0, 3};

        repeat (3) @(negedge clk);
        compare_all();
        rst = 1'b0;
        chk("rst_gnt",     {4'b0, gnt_o[0]},     8'h00);
        chk("rst_gnt_id",  {6'b0, gnt_id_o[0]},  8'h00);
        chk("rst_busy",    {7'b0, busy_o[0]},    8'h00);
        chk("rst_timeout", {7'b0, timeout_o[0]}, 8'h00);

        step(4'b0110, 1'b0, 1'b0);
        after_edge();
        chk("fix_0110_gnt",    {4'b0, gnt_o[0]},    8'h04);
        chk("fix_0110_gnt_id", {6'b0, gnt_id_o[0]}, 8'h02);
        step(4'b0110, 1'b1, 1'b0);
        after_edge();
        chk("done_gnt",  {4'b0, gnt_o[0]}, 8'h00);
        chk("done_busy", {7'b0, busy_o[0]}, 8'h00);
        step(4'b0000, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 1'b1, 1'b0);
            after_edge();
            chk("fix_all_gnt",    {4'b0, gnt_o[0]},    (k % 2 == 0) ? 8'h08 : 8'h00);
            chk("fix_all_gnt_id", {6'b0, gnt_id_o[0]}, 8'h03);
        end
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Hold timeout after 4 cycles, regrant, then done coinciding with the 4th cycle.
        for (int k = 0; k < 10; k++) begin
            step(4'b0001, (k == 9), 1'b0);
            after_edge();
            chk("hold_gnt",     {4'b0, gnt_o[0]},     (k == 4 || k == 9) ? 8'h00 : 8'h01);
            chk("hold_timeout", {7'b0, timeout_o[0]}, (k == 4) ? 8'h01 : 8'h00);
        end
        step(4'b0000, 1'b0, 1'b0);

        step(4'b1111, 1'b0, 1'b1);
        after_edge();
        chk("pre_rst_busy", {7'b0, busy_o[0]}, 8'h01);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("arst_i%0d_gnt", i),    {4'b0, gnt_o[i]},    8'h00);
            chk($sformatf("arst_i%0d_gnt_id", i), {6'b0, gnt_id_o[i]}, 8'h00);
            chk($sformatf("arst_i%0d_busy", i),   {7'b0, busy_o[i]},   8'h00);
        end
        #1;
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            step(4'b1111, 1'b1, 1'b1);
            after_edge();
            if (busy_o[0]) seq.push_back(int'(gnt_id_o[0]));
        end
        chk("rr_count", 8'(seq.size()), 8'd5);
        for (int j = 0; j < 5; j++)
            if (j < seq.size()) chk("rr_order", 8'(seq[j]), 8'(rr_exp[j]));
        step(4'b0000, 1'b0, 1'b0);

        r = 4'b0000;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            step(r, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
        end
        step(4'b0000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
